// File: rtl/lfsr_rng_arbiter.sv
// Shared 8-bit maximal-length LFSR with seed/warm-up sequencing and a
// round-robin arbiter that hands one registered random byte per cycle to a requester.
module lfsr_rng_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter logic [7:0]  DEFAULT_SEED = 8'hA5,
  parameter int unsigned WARMUP       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         seed,
  input  logic               load,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         rand_out,
  output logic               rand_valid,
  output logic               ready
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 4;

  typedef enum logic {WARM, SERVE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         lfsr_q, lfsr_d, lfsr_step;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]         rand_q, rand_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic [PTR_W-1:0]   win, idx;
  logic               found;

  // Fibonacci taps 8,6,5,4; the all-zero state is unreachable from a non-zero seed
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // First asserted request searching upward from the round-robin pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_step;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rand_d  = rand_q;
    valid_d = 1'b0;
    ready_d = 1'b0;
    if (load) begin
      // A zero seed would lock the LFSR, so the default is substituted
      lfsr_d  = (seed == 8'h00) ? DEFAULT_SEED : seed;
      state_d = WARM;
      cnt_d   = CNT_W'(WARMUP);
    end else if (state_q == WARM) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = SERVE;
      end
    end else if (found) begin
      gnt_d[win] = 1'b1;
      rand_d     = lfsr_q;
      valid_d    = 1'b1;
      ptr_d      = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
    ready_d = (state_d == SERVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WARM;
      cnt_q   <= CNT_W'(WARMUP);
      lfsr_q  <= DEFAULT_SEED;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rand_q  <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign gnt        = gnt_q;
  assign rand_out   = rand_q;
  assign rand_valid = valid_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Scoreboard bench for lfsr_rng_arbiter: a position-in-sequence reference model
// feeds expected per-cycle status and grant payloads to an independent monitor.
module tb_lfsr_rng_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned WU = 4;
  localparam logic [7:0]  DS = 8'hA5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [7:0]   seed = 8'h00;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [7:0]   rand_out;
  logic         rand_valid;
  logic         ready;

  always #5 clk = ~clk;

  lfsr_rng_arbiter #(.NUM_REQ(N), .DEFAULT_SEED(DS), .WARMUP(WU)) dut (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .req(req),
    .gnt(gnt), .rand_out(rand_out), .rand_valid(rand_valid), .ready(ready)
  );

  typedef struct packed { logic [N-1:0] g; logic [7:0] v; } grant_t;
  typedef struct packed { logic rdy; logic vld; } cyc_t;

  grant_t gq[$];
  cyc_t   cq[$];
  cyc_t   mc;
  grant_t mg;
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;

  // Reference: the 255-state cycle as a table, the LFSR as a position in it
  logic [7:0] seq [255];
  int         pos_of [256];
  int         m_pos, m_warm, m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic l, input logic [7:0] s, input logic [N-1:0] q);
    cyc_t c;
    int   w;
    c = '0;
    if (r) begin
      m_pos = pos_of[DS]; m_warm = WU; m_ptr = 0;
    end else if (l) begin
      m_pos = pos_of[(s == 8'h00) ? DS : s]; m_warm = WU;
    end else if (m_warm > 0) begin
      m_pos  = (m_pos + 1) % 255;
      m_warm = m_warm - 1;
      c.rdy  = (m_warm == 0);
    end else begin
      c.rdy = 1'b1;
      w = -1;
      for (int k = 0; k < int'(N); k++)
        if (w < 0 && q[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        gq.push_back({N'(1) << w, seq[m_pos]});
        m_ptr = (w + 1) % N;
        c.vld = 1'b1;
      end
      m_pos = (m_pos + 1) % 255;
    end
    cq.push_back(c);
  endtask

  task automatic cyc(input logic r, input logic l, input logic [7:0] s, input logic [N-1:0] q);
    @(negedge clk);
    rst = r; load = l; seed = s; req = q;
    mon_en = 1'b1;
    model_step(r, l, s, q);
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops expectations every cycle, grant payloads only when a grant is due
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_queue: got empty, expected an entry at %0t", $time);
      end else begin
        mc = cq.pop_front();
        chk("ready", 32'(ready), 32'(mc.rdy));
        chk("rand_valid", 32'(rand_valid), 32'(mc.vld));
        chk("valid_vs_gnt", 32'(rand_valid), 32'(gnt != '0));
        if (mc.vld && gq.size() > 0) begin
          mg = gq.pop_front();
          chk("gnt", 32'(gnt), 32'(mg.g));
          chk("rand_out", 32'(rand_out), 32'(mg.v));
        end else begin
          chk("gnt_idle", 32'(gnt), 32'h0);
        end
      end
    end
  end

  logic [N-1:0] exp_rr [5];
  logic [7:0]   prev_rand;
  logic [N-1:0] rq;
  logic [7:0]   rs;

  initial begin
    seq[0] = 8'h01;
    for (int i = 1; i < 255; i++)
      seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};
    for (int i = 0; i < 256; i++) pos_of[i] = 0;
    for (int i = 0; i < 255; i++) pos_of[seq[i]] = i;
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;

    // Reset and warm-up
    cyc(1, 0, 8'h00, '0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rand", 32'(rand_out), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 8'h00, '0);
      chk("warm_ready", 32'(ready), 0);
    end
    cyc(0, 0, 8'h00, '0);
    chk("warm_done_ready", 32'(ready), 1);

    // Seed 0x05, single request
    cyc(0, 1, 8'h05, '0);
    chk("load_ready", 32'(ready), 0);
    repeat (4) cyc(0, 0, 8'h00, '0);
    cyc(0, 0, 8'h00, 4'b0001);
    chk("seed05_gnt", 32'(gnt), 32'h1);
    chk("seed05_rand", 32'(rand_out), 32'h56);

    // Round-robin with all requests held, from a reset pointer
    cyc(1, 0, 8'h00, '0);
    cyc(0, 1, 8'h05, '0);
    repeat (4) cyc(0, 0, 8'h00, '0);
    prev_rand = 8'h00;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 8'h00, 4'b1111);
      chk("rr_gnt", 32'(gnt), 32'(exp_rr[i]));
      if (i == 0) chk("rr_rand0", 32'(rand_out), 32'h56);
      if (i == 1) chk("rr_rand1", 32'(rand_out), 32'hAD);
      if (i > 0) chk("rr_distinct", 32'(rand_out != prev_rand), 1);
      prev_rand = rand_out;
    end

    // Mid-service reload with the pointer at 2
    cyc(0, 0, 8'h00, 4'b1111);
    chk("pre_reload_gnt", 32'(gnt), 32'h2);
    cyc(0, 1, 8'h05, 4'b1111);
    chk("reload_gnt", 32'(gnt), 0);
    chk("reload_valid", 32'(rand_valid), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 8'h00, 4'b1111);
      chk("reload_warm_gnt", 32'(gnt), 0);
      chk("reload_warm_ready", 32'(ready), 32'(i == 3));
    end
    cyc(0, 0, 8'h00, 4'b1111);
    chk("reload_first_gnt", 32'(gnt), 32'h4);
    chk("reload_first_rand", 32'(rand_out), 32'h56);

    // Zero seed falls back to the default seed
    cyc(0, 1, 8'h00, '0);
    repeat (4) cyc(0, 0, 8'h00, '0);
    cyc(0, 0, 8'h00, 4'b0001);
    chk("zero_seed_gnt", 32'(gnt), 32'h1);
    chk("zero_seed_rand", 32'(rand_out), 32'h54);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, 8'h00, N'($urandom));
      if (rand_valid) chk("no_lockup", 32'(rand_out != 8'h00), 1);
    end

    // rst wins over load and req
    cyc(1, 1, 8'h33, 4'b1111);
    chk("rst_prio_gnt", 32'(gnt), 0);
    chk("rst_prio_ready", 32'(ready), 0);
    chk("rst_prio_rand", 32'(rand_out), 0);
    repeat (4) cyc(0, 0, 8'h00, 4'b1111);
    cyc(0, 0, 8'h00, 4'b1111);
    chk("rst_prio_first_gnt", 32'(gnt), 32'h1);
    chk("rst_prio_first_rand", 32'(rand_out), 32'h54);

    // Randomized traffic with occasional reloads and resets
    for (int i = 0; i < 2000; i++) begin
      rq = N'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 79) == 0), rs, rq);
    end
    cyc(0, 0, 8'h00, '0);

    chk("grant_queue_drained", 32'(gq.size()), 0);
    chk("status_queue_drained", 32'(cq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
